// File: rtl/seg7_scan_595.sv
// seg7_scan_595: multiplexed 7-segment scan engine driving a chain of 74HC595s.
// Each digit is decoded, framed with an active-low one-hot digit select,
// shifted out MSB first, latched, held for a dwell period, then the scan
// advances to the next digit.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (leading-zero blanking).
module seg7_scan_595 #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned NUM_ICS        = 2,
  parameter int unsigned SCLK_DIV       = 1,
  parameter int unsigned DWELL_CYCLES   = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                                                clk_i,
  input  logic                                                rst_ni,
  input  logic                                                enable_i,
  input  logic [4*NUM_DIGITS-1:0]                             digits_i,
  input  logic [NUM_DIGITS-1:0]                               dp_i,
  output logic                                                sclk_o,
  output logic                                                data_o,
  output logic                                                latch_en_o,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_o,
  output logic                                                busy_o,
  output logic                                                frame_done_o
);

  localparam int unsigned DIG_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned FRAME_BITS = 8 * NUM_ICS;
  localparam int unsigned BCNT_W     = $clog2(FRAME_BITS + 1);
  localparam int unsigned CNT_MAX    = (SCLK_DIV > DWELL_CYCLES) ? SCLK_DIV : DWELL_CYCLES;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
  localparam int unsigned SCLK_LAST  = SCLK_DIV - 1;
  localparam int unsigned DWELL_LAST = (DWELL_CYCLES == 0) ? 0 : DWELL_CYCLES - 1;

  // Reject parameter sets the frame format cannot represent.
  if (FRAME_BITS < 8 + NUM_DIGITS) begin : g_bad_frame
    $error("seg7_scan_595: 8*NUM_ICS must be at least 8+NUM_DIGITS");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("seg7_scan_595: NUM_DIGITS must be 1..8");
  end
  if (SCLK_DIV < 1) begin : g_bad_div
    $error("seg7_scan_595: SCLK_DIV must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_LATCH = 3'd3,
    S_DWELL = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sclk_hi_q, sclk_hi_d;
  logic [BCNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic [DIG_W-1:0]        digit_q, digit_d;
  logic                    frame_done_q, frame_done_d;
  logic                    sclk_q, sclk_d;
  logic                    data_q, data_d;
  logic                    latch_q, latch_d;
  logic                    busy_q, busy_d;
  logic                    advance;

  logic [3:0]              code_c;
  logic                    dp_c;
  logic                    blank_c;
  logic [7:0]              seg_byte_c;
  logic [FRAME_BITS-1:0]   frame_c;

  // Segment pattern {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] seg;
    unique case (code)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      4'd11:   seg = 7'h40;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  // Select the code and decimal point of the digit currently being scanned.
  always_comb begin
    code_c = 4'd0;
    dp_c   = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (digit_q == DIG_W'(i)) begin
        code_c = digits_i[4*i +: 4];
        dp_c   = dp_i[i];
      end
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic lead_c;

  // A zero is blanked while every digit to its left is zero or blank; the last digit always shows.
  always_comb begin
    lead_c  = 1'b1;
    blank_c = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS) - 1; i++) begin
      if (digit_q == DIG_W'(i)) begin
        blank_c = lead_c && (code_c == 4'd0);
      end
      lead_c = lead_c && ((digits_i[4*i +: 4] == 4'd0) || (digits_i[4*i +: 4] == 4'd10));
    end
  end
`else
  assign blank_c = 1'b0;
`endif

  // Build the frame: segment byte low, active-low digit select above, unused bits zero.
  always_comb begin
    seg_byte_c = {dp_c, (blank_c ? 7'h00 : seg_decode(code_c))};
    if (SEG_ACTIVE_LOW) begin
      seg_byte_c = ~seg_byte_c;
    end
    frame_c        = '0;
    frame_c[7:0]   = seg_byte_c;
    for (int j = 0; j < int'(NUM_DIGITS); j++) begin
      frame_c[8+j] = (digit_q != DIG_W'(j));
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath sequencing.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sclk_hi_d    = sclk_hi_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    digit_d      = digit_q;
    frame_done_d = 1'b0;
    advance      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        shreg_d   = frame_c;
        bit_cnt_d = BCNT_W'(FRAME_BITS);
        cnt_d     = '0;
        sclk_hi_d = 1'b0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_q == CNT_W'(SCLK_LAST)) begin
          cnt_d     = '0;
          sclk_hi_d = !sclk_hi_q;
          if (sclk_hi_q) begin
            shreg_d   = shreg_q << 1;
            bit_cnt_d = bit_cnt_q - BCNT_W'(1);
            if (bit_cnt_q == BCNT_W'(1)) begin
              state_d = S_LATCH;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LATCH: begin
        if (cnt_q == CNT_W'(SCLK_LAST)) begin
          cnt_d = '0;
          if (DWELL_CYCLES == 0) begin
            advance = 1'b1;
          end else begin
            state_d = S_DWELL;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DWELL: begin
        if (cnt_q == CNT_W'(DWELL_LAST)) begin
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (advance) begin
      cnt_d   = '0;
      state_d = enable_i ? S_LOAD : S_IDLE;
      if (digit_q == DIG_W'(NUM_DIGITS - 1)) begin
        digit_d      = '0;
        frame_done_d = 1'b1;
      end else begin
        digit_d = digit_q + DIG_W'(1);
      end
    end
  end

  // Next values of the pin outputs, derived from the upcoming state so they can be registered.
  always_comb begin
    sclk_d  = 1'b0;
    data_d  = 1'b0;
    latch_d = 1'b0;
    busy_d  = (state_d != S_IDLE);
    unique case (state_d)
      S_SHIFT: begin
        sclk_d = sclk_hi_d;
        data_d = shreg_d[FRAME_BITS-1];
      end
      S_LATCH: begin
        latch_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q        <= '0;
      sclk_hi_q    <= 1'b0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      digit_q      <= '0;
      frame_done_q <= 1'b0;
      sclk_q       <= 1'b0;
      data_q       <= 1'b0;
      latch_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sclk_hi_q    <= sclk_hi_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      digit_q      <= digit_d;
      frame_done_q <= frame_done_d;
      sclk_q       <= sclk_d;
      data_q       <= data_d;
      latch_q      <= latch_d;
      busy_q       <= busy_d;
    end
  end

  assign sclk_o       = sclk_q;
  assign data_o       = data_q;
  assign latch_en_o   = latch_q;
  assign digit_o      = digit_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;

endmodule
